// File: rtl/ddr3_test_pkg.sv
// Shared types and default widths for the DDR3 test master.
package ddr3_test_pkg;

    localparam int DDR3_ADDR_W = 26;
    localparam int DDR3_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_REQ  = 2'd1,
        ST_RD_REQ  = 2'd2,
        ST_RD_WAIT = 2'd3
    } ddr3_state_t;

endpackage

// File: rtl/ddr3_test_watchdog.sv
// Read-return watchdog: counts cycles while i_run is high and flags expiry
// on the TIMEOUT_CYCLES-th cycle.
module ddr3_test_watchdog #(
    parameter int TIMEOUT_CYCLES = 1023
)(
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || !i_run)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expire = i_run && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ddr3_test_master.sv
// Single-outstanding Avalon-MM test master for a DDR3 controller.
// Read watchdog is compiled in when DDR3_TEST_TIMEOUT_EN is defined.
module ddr3_test_master
    import ddr3_test_pkg::*;
#(
    parameter int ADDR_W         = DDR3_ADDR_W,
    parameter int DATA_W         = DDR3_DATA_W,
    parameter int TIMEOUT_CYCLES = 1023
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                test_wr_ddr3,
    input  logic                test_rd_ddr3,
    input  logic [31:0]         test_addr,
    input  logic [DATA_W-1:0]   test_wr_data,
    output logic [DATA_W-1:0]   test_rd_data,
    output logic                wr_finish,
    output logic                rd_finish,
    output logic                rd_timeout,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_write,
    output logic                avm_read,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    ddr3_state_t       r_state;
    logic              r_wr_pend;
    logic              r_rd_pend;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_write;
    logic              r_read;
    logic              r_wr_fin;
    logic              r_rd_fin;

    logic w_wr_req;
    logic w_rd_req;
    logic w_idle;
    logic w_start_wr;
    logic w_start_rd;
    logic w_in_wait;
    logic w_expire;
    logic w_unused;

    // A request is live if it is pulsing now or was parked while busy.
    assign w_wr_req   = test_wr_ddr3 | r_wr_pend;
    assign w_rd_req   = test_rd_ddr3 | r_rd_pend;
    assign w_idle     = (r_state == ST_IDLE);
    assign w_start_wr = w_idle & w_wr_req;
    assign w_start_rd = w_idle & ~w_wr_req & w_rd_req;
    assign w_in_wait  = (r_state == ST_RD_WAIT);

    assign w_unused = ^test_addr[31:ADDR_W] ^ (TIMEOUT_CYCLES == 0);

`ifdef DDR3_TEST_TIMEOUT_EN
    logic r_rd_timeout;

    ddr3_test_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .i_run    (w_in_wait),
        .o_expire (w_expire)
    );

    assign rd_timeout = r_rd_timeout;
`else
    assign w_expire   = 1'b0;
    assign rd_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_write   <= 1'b0;
            r_read    <= 1'b0;
            r_wr_fin  <= 1'b0;
            r_rd_fin  <= 1'b0;
`ifdef DDR3_TEST_TIMEOUT_EN
            r_rd_timeout <= 1'b0;
`endif
        end else begin
            r_wr_fin  <= 1'b0;
            r_rd_fin  <= 1'b0;
            // Parking flags are one deep, so repeats while set simply merge.
            r_wr_pend <= w_wr_req & ~w_start_wr;
            r_rd_pend <= w_rd_req & ~w_start_rd;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_wr) begin
                        r_addr  <= test_addr[ADDR_W-1:0];
                        r_wdata <= test_wr_data;
                        r_write <= 1'b1;
                        r_state <= ST_WR_REQ;
                    end else if (w_start_rd) begin
                        r_addr  <= test_addr[ADDR_W-1:0];
                        r_read  <= 1'b1;
                        r_state <= ST_RD_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (!avm_waitrequest) begin
                        r_write  <= 1'b0;
                        r_wr_fin <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (!avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        r_rdata  <= avm_readdata;
                        r_rd_fin <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else if (w_expire) begin
`ifdef DDR3_TEST_TIMEOUT_EN
                        r_rd_timeout <= 1'b1;
`endif
                        r_rd_fin <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign test_rd_data   = r_rdata;
    assign wr_finish      = r_wr_fin;
    assign rd_finish      = r_rd_fin;
    assign avm_address    = r_addr;
    assign avm_write      = r_write;
    assign avm_read       = r_read;
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = '1;

endmodule

// File: tb/tb_ddr3_test_master.sv
// Scoreboard bench for ddr3_test_master: randomized request bursts against a
// transaction-level model, a randomized Avalon slave, and directed corner cases.
module tb_ddr3_test_master;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 128;
    localparam int TMO    = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic                test_wr_ddr3, test_rd_ddr3;
    logic [31:0]         test_addr;
    logic [DATA_W-1:0]   test_wr_data;
    logic [DATA_W-1:0]   test_rd_data;
    logic                wr_finish, rd_finish, rd_timeout;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_write, avm_read;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;

    always #5 clk = ~clk;

    ddr3_test_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .test_wr_ddr3(test_wr_ddr3), .test_rd_ddr3(test_rd_ddr3),
        .test_addr(test_addr), .test_wr_data(test_wr_data),
        .test_rd_data(test_rd_data), .wr_finish(wr_finish), .rd_finish(rd_finish),
        .rd_timeout(rd_timeout), .avm_address(avm_address), .avm_write(avm_write),
        .avm_read(avm_read), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
    );

    typedef struct {
        bit                is_wr;
        logic [31:0]       addr;
        logic [DATA_W-1:0] data;
    } txn_t;

    txn_t exp_q[$];
    bit   fin_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [DATA_W-1:0] d);
        txn_t t;
        t.is_wr = w;
        t.addr  = a;
        t.data  = d;
        return t;
    endfunction

    function automatic logic [DATA_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- slave model ----------------
    int                force_stall  = -1;
    int                force_rd_dly = -1;
    bit                force_rd_dat = 0;
    logic [DATA_W-1:0] forced_dat   = '0;
    int                rd_cnt       = 0;
    bit                in_txn       = 0;
    int                stall        = 0;
    logic [DATA_W-1:0] ret_data     = '0;
    bit                abandon      = 0;
    bit                spurious_en  = 1;
    int                ncyc         = 0;
    int                acc_ncyc     = 0;

    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            avm_readdatavalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = force_rd_dat ? forced_dat : rnd128();
                    force_rd_dat = 0;
                    if (!abandon) ret_data = avm_readdata;
                end
            end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                // junk return while no read is outstanding: must be ignored
                avm_readdatavalid = 1'b1;
                avm_readdata      = rnd128();
            end
            if (avm_read === 1'b1 || avm_write === 1'b1) begin
                if (!in_txn) begin
                    in_txn = 1;
                    stall  = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
                    force_stall = -1;
                end
                if (stall > 0) begin
                    avm_waitrequest = 1'b1;
                    stall--;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_txn = 0;
                    if (avm_read === 1'b1) begin
                        rd_cnt = (force_rd_dly >= 0) ? force_rd_dly : int'($urandom_range(1, 6));
                        force_rd_dly = -1;
                        acc_ncyc = ncyc;
                    end
                end
            end else begin
                in_txn = 0;
                avm_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- monitor ----------------
    bit                prev_strobe = 0;
    int                len = 0;
    int                last_len = 0;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic              h_wr;
    txn_t              mt;
    bit                mdir;

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prev_strobe = 0;
            len = 0;
        end else begin
            if (avm_read && avm_write)
                chk("strobe_overlap", DATA_W'({avm_read, avm_write}), DATA_W'(0));
            if ((avm_read || avm_write) && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn", DATA_W'({avm_write, avm_read}), DATA_W'(0));
                end else begin
                    mt = exp_q.pop_front();
                    chk("txn_dir", DATA_W'(avm_write), DATA_W'(mt.is_wr));
                    chk("txn_addr", DATA_W'(avm_address), DATA_W'(mt.addr[ADDR_W-1:0]));
                    if (mt.is_wr) chk("txn_wdata", avm_writedata, mt.data);
                    chk("byteenable", DATA_W'(avm_byteenable), DATA_W'(16'hFFFF));
                end
                fin_q.push_back(avm_write);
                h_addr = avm_address; h_data = avm_writedata; h_wr = avm_write;
                len = 1;
            end else if (avm_read || avm_write) begin
                chk("hold_dir", DATA_W'(avm_write), DATA_W'(h_wr));
                chk("hold_addr", DATA_W'(avm_address), DATA_W'(h_addr));
                if (h_wr) chk("hold_wdata", avm_writedata, h_data);
                len++;
            end else if (prev_strobe) begin
                last_len = len;
            end
            prev_strobe = avm_read || avm_write;

            if (wr_finish || rd_finish) begin
                if (wr_finish && rd_finish)
                    chk("finish_overlap", DATA_W'({wr_finish, rd_finish}), DATA_W'(0));
                if (fin_q.size() == 0) begin
                    chk("unexpected_finish", DATA_W'({wr_finish, rd_finish}), DATA_W'(0));
                end else begin
                    mdir = fin_q.pop_front();
                    chk("finish_dir", DATA_W'(wr_finish), DATA_W'(mdir));
                    if (rd_finish) chk("rd_data", test_rd_data, ret_data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit exp_tmo = 0;

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || fin_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("burst_timeout", DATA_W'(n >= 300), DATA_W'(0));
        exp_q.delete();
        fin_q.delete();
        repeat (2) @(negedge clk);
        chk("idle_strobes", DATA_W'({avm_read, avm_write}), DATA_W'(0));
        chk("rd_data_kept", test_rd_data, ret_data);
        chk("rd_timeout", DATA_W'(rd_timeout), DATA_W'(exp_tmo));
    endtask

    // Burst: cycle 0 request(s) start the first transaction; cycles 1..k land
    // while it is busy. Pending ones capture a1/d1 at service start.
    task automatic burst(input bit w0, input bit r0, input int k,
                         input logic [3:0] ew, input logic [3:0] er,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                         input int stl);
        bit pw = 0;
        bit pr = w0 & r0;
        exp_q.push_back(mk(w0, a0, d0));
        for (int i = 0; i < k; i++) begin
            pw |= ew[i];
            pr |= er[i];
        end
        if (pw) exp_q.push_back(mk(1'b1, a1, d1));
        if (pr) exp_q.push_back(mk(1'b0, a1, d1));
        force_stall = stl;
        @(posedge clk); #1;
        test_wr_ddr3 = w0; test_rd_ddr3 = r0; test_addr = a0; test_wr_data = d0;
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            test_wr_ddr3 = ew[i]; test_rd_ddr3 = er[i]; test_addr = a1; test_wr_data = d1;
        end
        @(posedge clk); #1;
        test_wr_ddr3 = 1'b0; test_rd_ddr3 = 1'b0; test_addr = a1; test_wr_data = d1;
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1;
        test_wr_ddr3 = 1'b0; test_rd_ddr3 = 1'b0;
        test_addr = '0; test_wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_avm_read", DATA_W'(avm_read), DATA_W'(0));
        chk("rst_avm_write", DATA_W'(avm_write), DATA_W'(0));
        chk("rst_finish", DATA_W'({wr_finish, rd_finish}), DATA_W'(0));
        chk("rst_timeout", DATA_W'(rd_timeout), DATA_W'(0));
        chk("rst_addr", DATA_W'(avm_address), DATA_W'(0));
        chk("rst_wdata", avm_writedata, '0);
        chk("rst_rdata", test_rd_data, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // write with waitrequest held three cycles
        burst(1, 0, 0, 4'h0, 4'h0, 32'h100, 32'h100,
              128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D,
              128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 3);
        chk("wr_hold_len", DATA_W'(last_len), DATA_W'(4));

        // read with data returned five cycles after acceptance
        force_rd_dat = 1; forced_dat = 128'h00112233_44556677_8899AABB_CCDDEEFF; force_rd_dly = 5;
        burst(0, 1, 0, 4'h0, 4'h0, 32'h100, 32'h100, '0, '0, 0);
        chk("rd_fixed_data", test_rd_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);

        // simultaneous write and read: write first
        burst(1, 1, 0, 4'h0, 4'h0, 32'h0000_0200, 32'h0000_0300, rnd128(), rnd128(), -1);

        // three read pulses during one stalled write collapse into one read
        burst(1, 0, 3, 4'b0000, 4'b0111, 32'h0000_0400, 32'h0000_0500, rnd128(), rnd128(), 3);

        // upper address bits are dropped with no wrap arithmetic
        burst(1, 0, 0, 4'h0, 4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rnd128(), rnd128(), 0);

        // randomized bursts
        for (int n = 0; n < 40; n++) begin
            bit w0, r0;
            int k, stl;
            w0  = 1'($urandom_range(0, 1));
            r0  = w0 ? 1'($urandom_range(0, 1)) : 1'b1;
            k   = $urandom_range(0, 3);
            stl = (k > 0) ? (k - 1 + int'($urandom_range(0, 2))) : -1;
            burst(w0, r0, k, 4'($urandom), 4'($urandom), $urandom, $urandom, rnd128(), rnd128(), stl);
        end

        // reset while waiting for read data: abandoned, late return ignored
        spurious_en = 0;
        force_rd_dly = 8;
        exp_q.push_back(mk(1'b0, 32'h0000_0700, '0));
        @(posedge clk); #1;
        test_rd_ddr3 = 1'b1; test_addr = 32'h0000_0700;
        @(posedge clk); #1;
        test_rd_ddr3 = 1'b0;
        begin
            int n = 0;
            while (rd_cnt == 0 && n < 20) begin @(negedge clk); #1; n++; end
            chk("rst_rd_accept_timeout", DATA_W'(n >= 20), DATA_W'(0));
        end
        @(posedge clk); #1;
        abandon = 1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); fin_q.delete();
        ret_data = '0;
        repeat (12) @(negedge clk);
        chk("rst_mid_rdata", test_rd_data, '0);
        chk("rst_mid_strobes", DATA_W'({avm_read, avm_write}), DATA_W'(0));
        chk("rst_mid_pending_rd", DATA_W'(rd_cnt), DATA_W'(0));
        abandon = 0; spurious_en = 1;
        burst(1, 0, 0, 4'h0, 4'h0, 32'h0000_0800, 32'h0000_0800, rnd128(), rnd128(), 1);

`ifdef DDR3_TEST_TIMEOUT_EN
        // no read return: watchdog ends the read after TMO cycles in RD_WAIT
        spurious_en = 0;
        force_rd_dly = 1000;
        exp_q.push_back(mk(1'b0, 32'h0000_0900, '0));
        @(posedge clk); #1;
        test_rd_ddr3 = 1'b1; test_addr = 32'h0000_0900;
        @(posedge clk); #1;
        test_rd_ddr3 = 1'b0;
        begin
            int n = 0;
            while (rd_finish !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
            chk("tmo_finish_seen", DATA_W'(n >= 100), DATA_W'(0));
            chk("tmo_latency", DATA_W'(ncyc - acc_ncyc), DATA_W'(TMO + 1));
            chk("tmo_flag", DATA_W'(rd_timeout), DATA_W'(1));
        end
        rd_cnt = 0;
        exp_tmo = 1;
        wait_idle();
        spurious_en = 1;
        burst(1, 0, 0, 4'h0, 4'h0, 32'h0000_0A00, 32'h0000_0A00, rnd128(), rnd128(), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr3_test_master.md
DDR3_TEST_MASTER -- requirements
Module: ddr3_test_master

Interface
REQ-001 Parameter ADDR_W, default 26: DDR3 word-address width.
REQ-002 Parameter DATA_W, default 128: DDR3 data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1023: read watchdog limit; used only when the watchdog is compiled in.
REQ-004 Ports (clock and reset first):
- clk  in  1: DDR3 user clock; one clock.
- reset  in  1: synchronous reset, active-high.
- test_wr_ddr3  in  1: one-cycle write request pulse.
- test_rd_ddr3  in  1: one-cycle read request pulse.
- test_addr  in  32: word address; bits [ADDR_W-1:0] used.
- test_wr_data  in  DATA_W: write payload.
- test_rd_data  out  DATA_W: last read payload.
- wr_finish  out  1: write-complete pulse.
- rd_finish  out  1: read-complete pulse.
- rd_timeout  out  1: sticky watchdog flag.
- avm_address  out  ADDR_W: Avalon-MM address.
- avm_write  out  1: Avalon-MM write strobe.
- avm_read  out  1: Avalon-MM read strobe.
- avm_writedata  out  DATA_W: Avalon-MM write data.
- avm_byteenable  out  DATA_W/8: Avalon-MM byte enables.
- avm_waitrequest  in  1: slave stall.
- avm_readdata  in  DATA_W: read return data.
- avm_readdatavalid  in  1: read return strobe.

Function
REQ-005 FSM states: IDLE, WR_REQ, RD_REQ, RD_WAIT.
REQ-006 IDLE + write request (new or pending): latch test_addr and test_wr_data; next cycle enter WR_REQ with avm_write=1.
REQ-007 WR_REQ: hold avm_write, address and data stable while avm_waitrequest=1; on the first edge with avm_waitrequest=0, drop avm_write, pulse wr_finish for exactly one cycle, return to IDLE.
REQ-008 IDLE + read request: latch test_addr; enter RD_REQ with avm_read=1.
REQ-009 RD_REQ: hold avm_read while avm_waitrequest=1; on acceptance, drop avm_read and enter RD_WAIT.
REQ-010 RD_WAIT: on avm_readdatavalid=1, register avm_readdata into test_rd_data, pulse rd_finish for one cycle, return to IDLE.
REQ-011 Exactly one transaction is outstanding at a time; avm_read and avm_write are never high together.
REQ-012 Simultaneous test_wr_ddr3 and test_rd_ddr3: the write is served first and the read is held pending.
REQ-013 A request arriving while busy sets a one-deep pending flag per direction. Address and data are captured at service start. Further requests of the same direction while its flag is set are dropped.
REQ-014 On return to IDLE: a pending write is served before a pending read. There are no idle cycles between back-to-back transactions beyond the single IDLE cycle.
REQ-015 avm_byteenable is all ones. avm_address = latched test_addr[ADDR_W-1:0], with no wrap or offset arithmetic.
REQ-016 avm_readdatavalid outside RD_WAIT is ignored and does not change test_rd_data.

Reset
REQ-017 While reset=1, on the clock edge:
- FSM goes to IDLE; pending flags are cleared.
- avm_read, avm_write, wr_finish, rd_finish and rd_timeout go to 0.
- avm_address, avm_writedata and test_rd_data go to 0.
REQ-018 Reset mid-transaction abandons the transaction with no finish pulse; late readdatavalid is ignored per REQ-016.

Configuration
REQ-019 Macro DDR3_TEST_TIMEOUT_EN defined:
- A counter runs in RD_WAIT.
- After TIMEOUT_CYCLES cycles without readdatavalid: set rd_timeout (sticky until reset), pulse rd_finish, leave test_rd_data unchanged, return to IDLE.
REQ-020 Macro DDR3_TEST_TIMEOUT_EN undefined: no counter; rd_timeout is tied 0; RD_WAIT waits indefinitely.

Structure
REQ-021 Package ddr3_test_pkg holds the FSM state enum and the default ADDR_W/DATA_W constants.
REQ-022 Sub-module ddr3_test_watchdog (counter plus expiry compare) is instantiated only under DDR3_TEST_TIMEOUT_EN; pending flags stay inline.

Verification
REQ-023 Write, addr 0x100, data 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D, waitrequest high 3 cycles -> avm_write held 4 cycles with stable address/data; wr_finish pulses once.
REQ-024 Read, addr 0x100, readdatavalid 5 cycles after acceptance with 0x1122..FF -> test_rd_data = 0x1122..FF, rd_finish pulses once.
REQ-025 test_wr_ddr3 and test_rd_ddr3 in the same cycle -> write is issued first, then read; wr_finish precedes rd_finish; no overlapping strobes.
REQ-026 Three read pulses during one busy write -> exactly one read is issued after the write.
REQ-027 Reset asserted in RD_WAIT, then readdatavalid -> no rd_finish; test_rd_data = 0; state IDLE.
REQ-028 With DDR3_TEST_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no readdatavalid -> rd_timeout=1 and rd_finish pulses after 16 cycles; the next write still completes.
